axi2iob: RTL

AXI2IOB -- requirements
Module: axi2iob

---
 rtl/axi2iob_if.sv | 70 +++++++
 rtl/axi2iob.sv | 116 +++++++++++
 2 files changed

// File: rtl/axi2iob_if.sv
// axi2iob_if: AXI4 slave channels and IOb master bus bundled for the bridge
interface axi2iob_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int AXI_ID_WIDTH = 8
);
  logic [AXI_ID_WIDTH-1:0] axi_awid_i;
  logic [ADDR_WIDTH-1:0]   axi_awaddr_i;
  logic [7:0]              axi_awlen_i;
  logic [1:0]              axi_awburst_i;
  logic                    axi_awvalid_i;
  logic                    axi_awready_o;
  logic [DATA_WIDTH-1:0]   axi_wdata_i;
  logic [STRB_WIDTH-1:0]   axi_wstrb_i;
  logic                    axi_wlast_i;
  logic                    axi_wvalid_i;
  logic                    axi_wready_o;
  logic [AXI_ID_WIDTH-1:0] axi_bid_o;
  logic [1:0]              axi_bresp_o;
  logic                    axi_bvalid_o;
  logic                    axi_bready_i;
  logic [AXI_ID_WIDTH-1:0] axi_arid_i;
  logic [ADDR_WIDTH-1:0]   axi_araddr_i;
  logic [7:0]              axi_arlen_i;
  logic [1:0]              axi_arburst_i;
  logic                    axi_arvalid_i;
  logic                    axi_arready_o;
  logic [AXI_ID_WIDTH-1:0] axi_rid_o;
  logic [DATA_WIDTH-1:0]   axi_rdata_o;
  logic [1:0]              axi_rresp_o;
  logic                    axi_rlast_o;
  logic                    axi_rvalid_o;
  logic                    axi_rready_i;
  logic                    iob_avalid_o;
  logic [ADDR_WIDTH-1:0]   iob_addr_o;
  logic [DATA_WIDTH-1:0]   iob_wdata_o;
  logic [STRB_WIDTH-1:0]   iob_wstrb_o;
  logic [DATA_WIDTH-1:0]   iob_rdata_i;
  logic                    iob_rvalid_i;
  logic                    iob_ready_i;
  modport slave (
    input  axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awburst_i, axi_awvalid_i,
    output axi_awready_o,
    input  axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_wvalid_i,
    output axi_wready_o,
    output axi_bid_o, axi_bresp_o, axi_bvalid_o,
    input  axi_bready_i,
    input  axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arburst_i, axi_arvalid_i,
    output axi_arready_o,
    output axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o, axi_rvalid_o,
    input  axi_rready_i,
    output iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o,
    input  iob_rdata_i, iob_rvalid_i, iob_ready_i
  );
  modport master (
    output axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awburst_i, axi_awvalid_i,
    input  axi_awready_o,
    output axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_wvalid_i,
    input  axi_wready_o,
    input  axi_bid_o, axi_bresp_o, axi_bvalid_o,
    output axi_bready_i,
    output axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arburst_i, axi_arvalid_i,
    input  axi_arready_o,
    input  axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o, axi_rvalid_o,
    output axi_rready_i,
    input  iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o,
    output iob_rdata_i, iob_rvalid_i, iob_ready_i
  );
endinterface

// File: rtl/axi2iob.sv
// axi2iob: serves one AXI4 burst at a time as a sequence of single IOb accesses
module axi2iob #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int AXI_ID_WIDTH = 8
) (
  input logic clk_i,
  input logic arst_n_i,
  input logic cke_i,
  axi2iob_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_REQ, RD_WAIT, RD_RESP} state_t;
  state_t state, state_nxt;
  logic [AXI_ID_WIDTH-1:0] id;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [7:0] len, cnt;
  logic [1:0] burst, bresp;
  logic [DATA_WIDTH-1:0] rdata;
  logic pri_wr, err, en, last, gnt_w, gnt_r, grant, wbeat, rbeat, wlast_bad;
  // handshakes are suppressed while the clock is disabled so no transfer is acknowledged without being taken
  assign en = cke_i & arst_n_i;
  // the counter never passes len, so an 8-bit compare covers 256-beat bursts
  assign last = cnt == len;
  assign gnt_w = bus.axi_awvalid_i & (~bus.axi_arvalid_i | pri_wr);
  assign gnt_r = bus.axi_arvalid_i & (~bus.axi_awvalid_i | ~pri_wr);
  assign grant = state == IDLE & (gnt_w | gnt_r);
  assign wbeat = state == WR_DATA & bus.axi_wvalid_i & bus.iob_ready_i;
  assign rbeat = state == RD_RESP & bus.axi_rready_i;
  assign wlast_bad = bus.axi_wlast_i != last;
  assign addr_nxt = burst == 2'b00 ? addr : addr + ADDR_WIDTH'(STRB_WIDTH);
  assign bus.iob_addr_o = addr;
  assign bus.axi_bid_o = id;
  assign bus.axi_rid_o = id;
  assign bus.axi_bresp_o = bresp;
  assign bus.axi_rdata_o = rdata;
  assign bus.axi_rresp_o = 2'b00;
  // state register
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) state <= IDLE;
    else if (cke_i) state <= state_nxt;
  // next state and per-state bus outputs
  always_comb begin
    state_nxt = state;
    bus.axi_awready_o = 1'b0;
    bus.axi_arready_o = 1'b0;
    bus.axi_wready_o = 1'b0;
    bus.axi_bvalid_o = 1'b0;
    bus.axi_rvalid_o = 1'b0;
    bus.axi_rlast_o = 1'b0;
    bus.iob_avalid_o = 1'b0;
    bus.iob_wdata_o = '0;
    bus.iob_wstrb_o = '0;
    case (state)
      IDLE: begin
        bus.axi_awready_o = en & gnt_w;
        bus.axi_arready_o = en & gnt_r;
        state_nxt = gnt_w ? WR_DATA : gnt_r ? RD_REQ : IDLE;
      end
      WR_DATA: begin
        bus.iob_avalid_o = en & bus.axi_wvalid_i;
        bus.iob_wdata_o = bus.axi_wdata_i;
        bus.iob_wstrb_o = bus.axi_wstrb_i;
        bus.axi_wready_o = en & bus.iob_ready_i;
        state_nxt = wbeat & last ? WR_RESP : WR_DATA;
      end
      WR_RESP: begin
        bus.axi_bvalid_o = en;
        state_nxt = bus.axi_bready_i ? IDLE : WR_RESP;
      end
      RD_REQ: begin
        bus.iob_avalid_o = en;
        state_nxt = bus.iob_ready_i ? RD_WAIT : RD_REQ;
      end
      RD_WAIT: state_nxt = bus.iob_rvalid_i ? RD_RESP : RD_WAIT;
      RD_RESP: begin
        bus.axi_rvalid_o = en;
        bus.axi_rlast_o = last;
        state_nxt = rbeat ? (last ? IDLE : RD_REQ) : RD_RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // burst context, beat counter, write error tracking and read data capture
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      id <= '0;
      addr <= '0;
      len <= '0;
      burst <= '0;
      cnt <= '0;
      pri_wr <= 1'b1;
      err <= 1'b0;
      bresp <= 2'b00;
      rdata <= '0;
    end else if (cke_i) begin
      if (grant) begin
        id <= gnt_w ? bus.axi_awid_i : bus.axi_arid_i;
        addr <= gnt_w ? bus.axi_awaddr_i : bus.axi_araddr_i;
        len <= gnt_w ? bus.axi_awlen_i : bus.axi_arlen_i;
        burst <= gnt_w ? bus.axi_awburst_i : bus.axi_arburst_i;
        cnt <= '0;
        err <= 1'b0;
        pri_wr <= ~gnt_w;
      end
      if (wbeat) begin
        err <= err | wlast_bad;
        bresp <= err | wlast_bad ? 2'b10 : 2'b00;
      end
      if ((wbeat | rbeat) & ~last) begin
        cnt <= cnt + 8'd1;
        addr <= addr_nxt;
      end
      if (state == RD_WAIT & bus.iob_rvalid_i) rdata <= bus.iob_rdata_i;
    end
endmodule
